imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Instruction-fetch controller sitting between the word-addressed instruction memory and the decode stage. Owns the program counter, sequences one fetch per cycle, applies stalls and branch/JAL redirects from execute, and stops on a HALT opcode. Optionally fronts a boot-loader stream that fills instruction memory word by word before execution starts.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset and on leaving LOAD.
- IMEM_DEPTH, 1024, instruction memory size in 32-bit words; power of two.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  byte address to instruction memory; the memory indexes it with address[11:2].
- imem_rdata  in  32  combinational read data for imem_addr.
- imem_we  out  1  write strobe for the memory write port (loader only).
- imem_wdata  out  32  write data.
- stall  in  1  decode cannot accept; hold the fetch stage.
- redirect_valid  in  1  taken BEQ or JAL from execute.
- redirect_target  in  32  new PC, computed as (PC+4)+(imm<<2).
- if_valid  out  1  if_instr/if_pc hold a valid fetched instruction.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- if_pc_plus4  out  32  if_pc+4, used for the R7 link value.
- halted  out  1  HALT reached.
- fetch_count  out  32  number of instructions delivered with if_valid=1.
- load_valid  in  1  loader word available.
- load_data  in  32  loader word.
- load_done  in  1  loader finished.
- load_ready  out  1  controller accepts a loader word.

## Operation
- States: LOAD, RUN, HALT. Reset enters LOAD (macro defined) or RUN (macro undefined).
- LOAD: load_ready=1 while load_ptr<IMEM_DEPTH. On load_valid&&load_ready: imem_we=1, imem_addr=load_ptr*4, imem_wdata=load_data, then load_ptr+1. load_done moves the state to RUN at the next edge. If a word is accepted in the same cycle, that word is written first. Reaching load_ptr==IMEM_DEPTH forces load_ready=0 and moves to RUN without load_done. Entry to RUN sets pc=RESET_PC. if_valid=0 throughout LOAD.
- RUN: imem_addr=pc and imem_we=0. The following actions are listed by priority; the first that applies is taken.
  1. redirect_valid: pc<=redirect_target&~3 (low bits forced to zero) and if_valid<=0. This flushes the wrong-path instruction even under stall.
  2. stall: pc and all if_* outputs are held.
  3. Otherwise: if_instr<=imem_rdata, if_pc<=pc, if_pc_plus4<=pc+4, if_valid<=1, pc<=pc+4, fetch_count+1.
- HALT detect: the fetched word has opcode imem_rdata[31:27]==5'b11111 and action 3 applies. The HALT word is delivered with if_valid=1 and the state moves to HALT. A HALT word fetched in a cycle with redirect_valid is discarded.
- HALT: halted=1. if_valid drops once decode consumes the HALT word, meaning the first edge with stall=0. There is no further fetching, and redirects are ignored. Only rst exits HALT.
- PC arithmetic is modulo 2^32. The memory index wraps at IMEM_DEPTH naturally because only [11:2] is used.

## Timing
- Reset values of outputs: if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, halted=0, fetch_count=0, imem_we=0, imem_wdata=0. load_ready=1 in LOAD, otherwise 0. imem_addr=0 in LOAD, otherwise RESET_PC.
- Internal reset values: pc=RESET_PC, load_ptr=0.
- Fetch latency is 1 cycle, from pc presented on imem_addr to the registered if_*. Throughput is 1 instruction per cycle when there is no stall.
- A redirect produces exactly one bubble. The target instruction shows if_valid=1 two edges after the redirect cycle.
- rst asserted at any time, including mid-LOAD or mid-stall, has the following effect at that edge:
  - All state returns to its reset value.
  - The partial load is abandoned; memory contents are not cleared.

## Configuration
- BOOT_LOADER_EN defined: LOAD state and loader handshake are present as described.
- BOOT_LOADER_EN undefined:
  - The LOAD state is removed and reset enters RUN directly.
  - load_ready=0 and imem_we=0 constantly; imem_wdata=0.
  - load_* inputs are ignored.

## Test plan
- Linear fetch: Reset with RESET_PC=0 and no stall, memory preloaded with ADDI R1,R0,10 at word 0. Required: at edge 1, if_valid=1, if_pc=0, if_instr={5'b00011,3'b000,3'b001,5'b0,16'd10}. At edge 2, if_pc=4. fetch_count increments once per edge.
- Stall: Assert stall for 3 cycles while if_pc=8. Required: if_pc=8 and if_instr unchanged; pc held; fetch_count frozen. After release, the next if_pc is 12.
- Redirect: At if_pc=24, assert redirect_valid with target 44 (JAL +3 from word 7) together with stall=1. Required: next edge if_valid=0; following edge if_pc=44, if_valid=1. A target of 47 yields 44.
- HALT: Place 32'hF800_0000 at word 3. Required:
  - The word is delivered with if_valid=1 and if_pc=12, and halted=1 on the next edge.
  - imem_addr is frozen, later redirects are ignored, and fetch_count=4.
  - With redirect_valid in the HALT fetch cycle, the controller does not halt.
- Loader (BOOT_LOADER_EN): Stream 3 words 0xA,0xB,0xC with a gap cycle, then load_done in the same cycle as word 0xC. Required:
  - imem_we pulses at addresses 0, 4 and 8.
  - RUN is entered the next edge with pc=RESET_PC.
  - Asserting rst mid-stream returns the controller to LOAD with load_ptr=0.
- Loader full: Stream IMEM_DEPTH words without load_done. Required: load_ready falls after word 1023 and the controller auto-enters RUN.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction-fetch controller: PC, stall/redirect, HALT, optional boot loader
// Optional feature macro: BOOT_LOADER_EN (adds the LOAD state and loader handshake).
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        imem_we,
  output logic [31:0] imem_wdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted,
  output logic [31:0] fetch_count,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        load_ready
);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic        fetch_go;
  logic        is_halt_op;

  // A fetch is delivered only in RUN when neither redirect nor stall wins
  assign fetch_go   = (state == S_RUN) && !redirect_valid && !stall;
  assign is_halt_op = (imem_rdata[31:27] == 5'b11111);

`ifdef BOOT_LOADER_EN
  localparam int            AW        = $clog2(IMEM_DEPTH);
  localparam logic [AW:0]   DEPTH_V   = (AW+1)'(IMEM_DEPTH);
  localparam logic [AW:0]   LAST_IDX  = (AW+1)'(IMEM_DEPTH - 1);
  localparam state_t        RESET_ST  = S_LOAD;

  logic [AW:0] load_ptr;
  logic        load_fire;
  logic        load_last;

  assign load_fire = load_valid && load_ready;
  // Accepting the final word leaves LOAD on the same edge, so memory fills without load_done
  assign load_last = load_fire && (load_ptr == LAST_IDX);
`else
  localparam state_t RESET_ST = S_RUN;
  localparam int     unused_depth = IMEM_DEPTH;

  logic unused_load;
  assign unused_load = ^{load_valid, load_done, load_data};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RESET_ST;
    else     state <= state_nx;
  end

  // Next-state: LOAD exits on load_done or full memory; RUN halts on a delivered HALT word
  always_comb begin
    state_nx = state;
    case (state)
`ifdef BOOT_LOADER_EN
      S_LOAD: if (load_done || load_last || (load_ptr == DEPTH_V)) state_nx = S_RUN;
`else
      S_LOAD: state_nx = S_RUN;
`endif
      S_RUN:  if (fetch_go && is_halt_op) state_nx = S_HALT;
      S_HALT: state_nx = S_HALT;
      default: state_nx = RESET_ST;
    endcase
  end

  // Outputs: memory port is owned by the loader in LOAD and by the PC otherwise
  always_comb begin
    imem_addr  = pc;
    imem_we    = 1'b0;
    imem_wdata = 32'h0;
    load_ready = 1'b0;
    halted     = (state == S_HALT);
`ifdef BOOT_LOADER_EN
    if (state == S_LOAD) begin
      imem_addr  = {{(30-AW){1'b0}}, load_ptr[AW-1:0], 2'b00};
      load_ready = (load_ptr < DEPTH_V);
      imem_we    = load_valid && (load_ptr < DEPTH_V);
      imem_wdata = imem_we ? load_data : 32'h0;
    end
`endif
  end

  // Datapath: PC, fetch registers, delivered-instruction counter and loader pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'h0;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      fetch_count <= 32'h0;
`ifdef BOOT_LOADER_EN
      load_ptr    <= '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
`ifdef BOOT_LOADER_EN
          if (load_fire) load_ptr <= load_ptr + 1'b1;
          if (state_nx == S_RUN) pc <= RESET_PC;
`endif
        end
        S_RUN: begin
          if (redirect_valid) begin
            // Redirect flushes the wrong-path word even while decode is stalled
            pc       <= redirect_target & ~32'd3;
            if_valid <= 1'b0;
          end else if (!stall) begin
            if_instr    <= imem_rdata;
            if_pc       <= pc;
            if_pc_plus4 <= pc + 32'd4;
            if_valid    <= 1'b1;
            pc          <= pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        S_HALT: begin
          // HALT word stays presented until decode takes it
          if (!stall) if_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
